minefield_game_ctrl: RTL and testbench

Top-level game sequencer for the minesweeper datapath. It accepts a new-game request and difficulty, latches the field configuration, and drives the field filler's start/finish handshake with a timeout. It then tracks player reveals to detect win or loss and runs the on-screen seconds timer. It sits between the button/input logic and the field filler, and feeds status to the SVGA renderer.

---
 rtl/minefield_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_minefield_game_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minefield_game_ctrl.sv
// Game sequencer: new-game accept, filler handshake with timeout, win/loss tracking, seconds timer.
// Optional build macro FIRST_CLICK_SAFE_EN regenerates the field when the first fresh reveal is a mine.
module minefield_game_ctrl #(
    parameter int MAX_CELL_WIDTH  = 30,
    parameter int MAX_CELL_HEIGHT = 16,
    parameter int MINES_W         = 7,
    parameter int CLK_FREQ_HZ     = 40_000_000,
    parameter int FILL_TIMEOUT    = 65535,
    localparam int CW = $clog2(MAX_CELL_WIDTH),
    localparam int CH = $clog2(MAX_CELL_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game_i,
    input  logic [1:0]         difficulty_i,
    output logic               fill_start_o,
    input  logic               fill_finished_i,
    output logic [CW-1:0]      field_width_o,
    output logic [CH-1:0]      field_height_o,
    output logic [MINES_W-1:0] mines_count_o,
    input  logic               reveal_i,
    input  logic               reveal_fresh_i,
    input  logic               reveal_is_mine_i,
    output logic               reveal_retry_o,
    output logic               busy_o,
    output logic               playing_o,
    output logic               won_o,
    output logic               lost_o,
    output logic               fault_o,
    output logic [9:0]         seconds_o
);

    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int TW = $clog2(FILL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PLAY,
        S_WON,
        S_LOST,
        S_FAULT
    } state_t;

    state_t              state, state_n;
    logic [8:0]          safe_left;
    logic [PW-1:0]       presc;
    logic [TW-1:0]       tmo_cnt;
    logic                accept;
    logic                fresh_rev;
    logic                regen;
    logic [CW-1:0]       p_w;
    logic [CH-1:0]       p_h;
    logic [MINES_W-1:0]  p_m;
    logic [8:0]          p_safe;
    int                  p_area;

    always_comb begin
        p_w = CW'(9);
        p_h = CH'(9);
        p_m = MINES_W'(10);
        case (difficulty_i)
            2'd1: begin
                p_w = CW'(15);
                p_h = CH'(15);
                p_m = MINES_W'(40);
            end
            2'd2: begin
                p_w = CW'(29);
                p_h = CH'(15);
                p_m = MINES_W'(99);
            end
            default: ;
        endcase
        p_area = int'(p_w) * int'(p_h) - int'(p_m);
        p_safe = p_area[8:0];
    end

    assign accept    = new_game_i && (state != S_FILL);
    // A same-cycle new game drops the reveal entirely.
    assign fresh_rev = (state == S_PLAY) && reveal_i && reveal_fresh_i && !new_game_i;

`ifdef FIRST_CLICK_SAFE_EN
    logic first_reveal;
    logic retry_pend;
    assign regen = fresh_rev && reveal_is_mine_i && first_reveal;
`else
    assign regen = 1'b0;
    assign reveal_retry_o = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_FILL: begin
                if (fill_finished_i)
                    state_n = S_PLAY;
                else if (tmo_cnt == TW'(FILL_TIMEOUT - 1))
                    state_n = S_FAULT;
            end
            S_PLAY: begin
                if (regen)
                    state_n = S_FILL;
                else if (fresh_rev && reveal_is_mine_i)
                    state_n = S_LOST;
                else if (fresh_rev && (safe_left == 9'd1))
                    state_n = S_WON;
            end
            default: ;
        endcase
        if (accept)
            state_n = S_FILL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            busy_o         <= 1'b0;
            playing_o      <= 1'b0;
            won_o          <= 1'b0;
            lost_o         <= 1'b0;
            fault_o        <= 1'b0;
            fill_start_o   <= 1'b0;
            field_width_o  <= CW'(9);
            field_height_o <= CH'(9);
            mines_count_o  <= MINES_W'(10);
            safe_left      <= 9'd71;
            presc          <= '0;
            seconds_o      <= '0;
            tmo_cnt        <= '0;
        end else begin
            state        <= state_n;
            busy_o       <= (state_n == S_FILL);
            playing_o    <= (state_n == S_PLAY);
            won_o        <= (state_n == S_WON);
            lost_o       <= (state_n == S_LOST);
            fault_o      <= (state_n == S_FAULT);
            fill_start_o <= accept || regen;
            if (accept) begin
                field_width_o  <= p_w;
                field_height_o <= p_h;
                mines_count_o  <= p_m;
                safe_left      <= p_safe;
                presc          <= '0;
                seconds_o      <= '0;
                tmo_cnt        <= '0;
            end else begin
                if (regen)
                    tmo_cnt <= '0;
                else if (state == S_FILL)
                    tmo_cnt <= tmo_cnt + 1'b1;
                if (fresh_rev && !reveal_is_mine_i)
                    safe_left <= safe_left - 9'd1;
                if (state == S_PLAY) begin
                    if (presc == PW'(CLK_FREQ_HZ - 1)) begin
                        presc <= '0;
                        if (seconds_o < 10'd999)
                            seconds_o <= seconds_o + 10'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end
        end
    end

`ifdef FIRST_CLICK_SAFE_EN
    // Retry request fires as the regenerated field comes back into play.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_reveal   <= 1'b0;
            retry_pend     <= 1'b0;
            reveal_retry_o <= 1'b0;
        end else begin
            reveal_retry_o <= 1'b0;
            if (accept) begin
                first_reveal <= 1'b1;
                retry_pend   <= 1'b0;
            end else begin
                if (fresh_rev && !reveal_is_mine_i)
                    first_reveal <= 1'b0;
                if (regen)
                    retry_pend <= 1'b1;
                else if ((state == S_FILL) && fill_finished_i) begin
                    retry_pend     <= 1'b0;
                    reveal_retry_o <= retry_pend;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_minefield_game_ctrl.sv
// Directed bench for minefield_game_ctrl with a fast timer (10 cycles/second) and a 50-cycle fill timeout.
module tb_minefield_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_game_i;
    logic [1:0] difficulty_i;
    logic       fill_start_o;
    logic       fill_finished_i;
    logic [4:0] field_width_o;
    logic [3:0] field_height_o;
    logic [6:0] mines_count_o;
    logic       reveal_i;
    logic       reveal_fresh_i;
    logic       reveal_is_mine_i;
    logic       reveal_retry_o;
    logic       busy_o;
    logic       playing_o;
    logic       won_o;
    logic       lost_o;
    logic       fault_o;
    logic [9:0] seconds_o;

    int n_assert = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;

    minefield_game_ctrl #(
        .CLK_FREQ_HZ (10),
        .FILL_TIMEOUT(50)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .new_game_i      (new_game_i),
        .difficulty_i    (difficulty_i),
        .fill_start_o    (fill_start_o),
        .fill_finished_i (fill_finished_i),
        .field_width_o   (field_width_o),
        .field_height_o  (field_height_o),
        .mines_count_o   (mines_count_o),
        .reveal_i        (reveal_i),
        .reveal_fresh_i  (reveal_fresh_i),
        .reveal_is_mine_i(reveal_is_mine_i),
        .reveal_retry_o  (reveal_retry_o),
        .busy_o          (busy_o),
        .playing_o       (playing_o),
        .won_o           (won_o),
        .lost_o          (lost_o),
        .fault_o         (fault_o),
        .seconds_o       (seconds_o)
    );

    always #5 clk = ~clk;

    // Count start pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (fill_start_o)
            fs_cnt <= fs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic reveal(input logic fresh, input logic mine);
        reveal_i         = 1'b1;
        reveal_fresh_i   = fresh;
        reveal_is_mine_i = mine;
        tick();
        reveal_i         = 1'b0;
        reveal_fresh_i   = 1'b0;
        reveal_is_mine_i = 1'b0;
    endtask

    task automatic start_game(input logic [1:0] diff, input int fill_delay);
        new_game_i   = 1'b1;
        difficulty_i = diff;
        tick();
        new_game_i = 1'b0;
        ticks(fill_delay);
        fill_finished_i = 1'b1;
        tick();
        fill_finished_i = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        new_game_i       = 1'b0;
        difficulty_i     = 2'd0;
        fill_finished_i  = 1'b0;
        reveal_i         = 1'b0;
        reveal_fresh_i   = 1'b0;
        reveal_is_mine_i = 1'b0;
        ticks(3);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_play", 32'(playing_o), 0);
        chk("rst_won", 32'(won_o), 0);
        chk("rst_lost", 32'(lost_o), 0);
        chk("rst_fault", 32'(fault_o), 0);
        chk("rst_fstart", 32'(fill_start_o), 0);
        chk("rst_secs", 32'(seconds_o), 0);
        chk("rst_width", 32'(field_width_o), 9);
        chk("rst_height", 32'(field_height_o), 9);
        chk("rst_mines", 32'(mines_count_o), 10);
        chk("rst_retry", 32'(reveal_retry_o), 0);
        rst = 1'b1;
        ticks(2);
        chk("idle_busy", 32'(busy_o), 0);

        // Expert game, filler answers 20 cycles after the request.
        new_game_i   = 1'b1;
        difficulty_i = 2'd2;
        tick();
        new_game_i = 1'b0;
        chk("exp_width", 32'(field_width_o), 29);
        chk("exp_height", 32'(field_height_o), 15);
        chk("exp_mines", 32'(mines_count_o), 99);
        chk("exp_fstart", 32'(fill_start_o), 1);
        chk("exp_busy", 32'(busy_o), 1);
        tick();
        chk("exp_fstart_drop", 32'(fill_start_o), 0);
        chk("exp_fs_cnt", 32'(fs_cnt), 1);
        ticks(18);
        chk("exp_still_busy", 32'(busy_o), 1);
        fill_finished_i = 1'b1;
        tick();
        fill_finished_i = 1'b0;
        chk("exp_playing", 32'(playing_o), 1);
        chk("exp_busy_off", 32'(busy_o), 0);

        // Beginner: 71 fresh safe reveals with 5 non-fresh ones mixed in.
        start_game(2'd0, 4);
        chk("beg_playing", 32'(playing_o), 1);
        chk("beg_width", 32'(field_width_o), 9);
        for (int i = 0; i < 71; i++) begin
            if (i % 12 == 11)
                reveal(1'b0, 1'b0);
            if (i == 70) begin
                chk("win_not_yet_play", 32'(playing_o), 1);
                chk("win_not_yet_won", 32'(won_o), 0);
            end
            reveal(1'b1, 1'b0);
        end
        chk("win_won", 32'(won_o), 1);
        chk("win_play_off", 32'(playing_o), 0);
        chk("win_secs", 32'(seconds_o), 7);
        ticks(30);
        chk("win_secs_frozen", 32'(seconds_o), 7);
        chk("win_hold", 32'(won_o), 1);

        // Beginner: three safe reveals, idle, then a mine.
        start_game(2'd0, 5);
        reveal(1'b1, 1'b0);
        reveal(1'b1, 1'b0);
        reveal(1'b1, 1'b0);
        ticks(20);
        reveal(1'b1, 1'b1);
        chk("loss_lost", 32'(lost_o), 1);
        chk("loss_play_off", 32'(playing_o), 0);
        chk("loss_secs", 32'(seconds_o), 2);
        reveal(1'b1, 1'b1);
        chk("loss_reveal_ignored", 32'(lost_o), 1);
        fill_finished_i = 1'b1;
        tick();
        fill_finished_i = 1'b0;
        chk("loss_ff_ignored", 32'(lost_o), 1);
        chk("loss_ff_no_play", 32'(playing_o), 0);
        ticks(15);
        chk("loss_secs_frozen", 32'(seconds_o), 2);
        new_game_i   = 1'b1;
        difficulty_i = 2'd0;
        tick();
        new_game_i = 1'b0;
        chk("loss_new_busy", 32'(busy_o), 1);
        chk("loss_new_lost_off", 32'(lost_o), 0);
        chk("loss_new_secs", 32'(seconds_o), 0);
        chk("loss_new_fstart", 32'(fill_start_o), 1);

        // Filler never answers: timeout after 50 FILL cycles; new game in FILL ignored.
        ticks(9);
        new_game_i   = 1'b1;
        difficulty_i = 2'd2;
        tick();
        new_game_i = 1'b0;
        chk("tmo_ng_ignored_w", 32'(field_width_o), 9);
        chk("tmo_ng_ignored_fs", 32'(fill_start_o), 0);
        ticks(39);
        chk("tmo_busy_49", 32'(busy_o), 1);
        chk("tmo_fault_49", 32'(fault_o), 0);
        chk("tmo_fs_cnt", 32'(fs_cnt), 4);
        tick();
        chk("tmo_fault_50", 32'(fault_o), 1);
        chk("tmo_busy_50", 32'(busy_o), 0);
        new_game_i   = 1'b1;
        difficulty_i = 2'd1;
        tick();
        new_game_i = 1'b0;
        chk("fault_accept_busy", 32'(busy_o), 1);
        chk("fault_accept_fault", 32'(fault_o), 0);
        chk("int_width", 32'(field_width_o), 15);
        chk("int_height", 32'(field_height_o), 15);
        chk("int_mines", 32'(mines_count_o), 40);
        ticks(3);
        fill_finished_i = 1'b1;
        tick();
        fill_finished_i = 1'b0;
        chk("int_playing", 32'(playing_o), 1);
        chk("int_fs_cnt", 32'(fs_cnt), 5);

        // Timer saturation.
        ticks(9990);
        chk("sat_999", 32'(seconds_o), 999);
        ticks(110);
        chk("sat_hold", 32'(seconds_o), 999);
        chk("sat_playing", 32'(playing_o), 1);

        // New game and mine reveal in the same cycle: new game wins.
        new_game_i       = 1'b1;
        difficulty_i     = 2'd0;
        reveal_i         = 1'b1;
        reveal_fresh_i   = 1'b1;
        reveal_is_mine_i = 1'b1;
        tick();
        new_game_i       = 1'b0;
        reveal_i         = 1'b0;
        reveal_fresh_i   = 1'b0;
        reveal_is_mine_i = 1'b0;
        chk("race_busy", 32'(busy_o), 1);
        chk("race_lost", 32'(lost_o), 0);
        chk("race_secs", 32'(seconds_o), 0);
        chk("race_width", 32'(field_width_o), 9);
        tick();
        chk("race_lost_later", 32'(lost_o), 0);
        ticks(2);
        fill_finished_i = 1'b1;
        tick();
        fill_finished_i = 1'b0;
        chk("race_playing", 32'(playing_o), 1);

        // First fresh reveal hits a mine.
        reveal(1'b1, 1'b1);
`ifdef FIRST_CLICK_SAFE_EN
        chk("fc_busy", 32'(busy_o), 1);
        chk("fc_lost", 32'(lost_o), 0);
        chk("fc_fstart", 32'(fill_start_o), 1);
        chk("fc_width", 32'(field_width_o), 9);
        chk("fc_mines", 32'(mines_count_o), 10);
        chk("fc_retry_early", 32'(reveal_retry_o), 0);
        tick();
        chk("fc_fstart_drop", 32'(fill_start_o), 0);
        fill_finished_i = 1'b1;
        tick();
        fill_finished_i = 1'b0;
        chk("fc_playing", 32'(playing_o), 1);
        chk("fc_retry", 32'(reveal_retry_o), 1);
        tick();
        chk("fc_retry_drop", 32'(reveal_retry_o), 0);
        reveal(1'b1, 1'b0);
        chk("fc_safe_play", 32'(playing_o), 1);
`else
        chk("fc_lost", 32'(lost_o), 1);
        chk("fc_busy", 32'(busy_o), 0);
        chk("fc_fstart", 32'(fill_start_o), 0);
        chk("fc_retry", 32'(reveal_retry_o), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
